// File: rtl/lfsr_sched.sv
// lfsr_sched: round-robin noise-voice scheduler; one shared LFSR step engine serves all voices.
// Optional LFSR_SCHED_LOCKUP_GUARD_EN: an all-zero step result is replaced by all-ones.

module lfsr_sched_voice #(
    parameter int DEPTH = 8,
    parameter int DIVW  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [DIVW-1:0]  cfg_period,
    input  logic [DEPTH-1:0] cfg_taps,
    input  logic             cfg_dir,
    input  logic             cfg_enable,
    input  logic             cfg_seed,
    input  logic             wb_en,
    input  logic [DEPTH-1:0] wb_state,
    output logic [DEPTH-1:0] state,
    output logic [DEPTH-1:0] taps,
    output logic             dir,
    output logic             pending,
    output logic             overrun
);
    logic [DIVW-1:0] period;
    logic [DIVW-1:0] cnt;
    logic            enable;
    logic            expire;

    assign expire = enable && (cnt == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= '1;
            taps    <= '0;
            dir     <= 1'b0;
            enable  <= 1'b0;
            period  <= '0;
            cnt     <= '0;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else if (cfg_we) begin
            taps    <= cfg_taps;
            dir     <= cfg_dir;
            enable  <= cfg_enable;
            period  <= cfg_period;
            cnt     <= cfg_period;
            pending <= 1'b0;
            overrun <= 1'b0;
            // A seeding write overrides a concurrent write-back; otherwise the stepped value survives.
            if (cfg_seed)
                state <= '1;
            else if (wb_en)
                state <= wb_state;
        end else begin
            if (wb_en)
                state <= wb_state;
            if (expire) begin
                cnt     <= period;
                pending <= 1'b1;
                if (pending && !wb_en)
                    overrun <= 1'b1;
            end else begin
                if (enable)
                    cnt <= cnt - 1'b1;
                if (wb_en)
                    pending <= 1'b0;
            end
        end
    end
endmodule

module lfsr_sched #(
    parameter int DEPTH  = 8,
    parameter int VOICES = 4,
    parameter int DIVW   = 16,
    parameter int VW     = $clog2(VOICES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cfg_we,
    input  logic [VW-1:0]           cfg_voice,
    input  logic [DIVW-1:0]         cfg_period,
    input  logic [DEPTH-1:0]        cfg_taps,
    input  logic                    cfg_dir,
    input  logic                    cfg_enable,
    input  logic                    cfg_seed,
    output logic [VOICES*DEPTH-1:0] value_bus,
    output logic [VOICES-1:0]       noise,
    output logic                    upd_valid,
    output logic [VW-1:0]           upd_voice,
    output logic [VOICES-1:0]       overrun,
    output logic                    busy
);
    typedef enum logic {S_IDLE, S_STEP} fsm_t;

    fsm_t                         st, st_nxt;
    logic [VW-1:0]                rr_ptr, grant, sel;
    logic                         any_pend;
    logic [VOICES-1:0]            pending, dir_w, wb_en;
    logic [VOICES-1:0][DEPTH-1:0] state_w, taps_w;
    logic [DEPTH-1:0]             cur, cur_taps, raw, step_res;
    logic                         cur_dir, fb;

    for (genvar v = 0; v < VOICES; v++) begin : g_voice
        assign wb_en[v] = (st == S_STEP) && (grant == VW'(v));

        lfsr_sched_voice #(.DEPTH(DEPTH), .DIVW(DIVW)) u_voice (
            .clk        (clk),
            .reset      (reset),
            .cfg_we     (cfg_we && (cfg_voice == VW'(v))),
            .cfg_period (cfg_period),
            .cfg_taps   (cfg_taps),
            .cfg_dir    (cfg_dir),
            .cfg_enable (cfg_enable),
            .cfg_seed   (cfg_seed),
            .wb_en      (wb_en[v]),
            .wb_state   (step_res),
            .state      (state_w[v]),
            .taps       (taps_w[v]),
            .dir        (dir_w[v]),
            .pending    (pending[v]),
            .overrun    (overrun[v])
        );

        assign noise[v] = state_w[v][0];
    end

    assign value_bus = state_w;
    assign busy      = (st == S_STEP);

    // Shared step engine, fed from the granted voice.
    assign cur      = state_w[grant];
    assign cur_taps = taps_w[grant];
    assign cur_dir  = dir_w[grant];
    assign fb       = ^(cur & cur_taps);
    assign raw      = cur_dir ? {cur[DEPTH-2:0], fb} : {fb, cur[DEPTH-1:1]};

`ifdef LFSR_SCHED_LOCKUP_GUARD_EN
    assign step_res = (raw == '0) ? '1 : raw;
`else
    assign step_res = raw;
`endif

    // Walk from the highest offset down so the nearest pending voice after rr_ptr wins.
    always_comb begin
        logic [VW:0]   sum;
        logic [VW-1:0] idx;
        sel      = rr_ptr;
        any_pend = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int i = VOICES - 1; i >= 0; i--) begin
            sum = {1'b0, rr_ptr} + (VW+1)'(i);
            if (sum >= (VW+1)'(VOICES))
                sum = sum - (VW+1)'(VOICES);
            idx = sum[VW-1:0];
            if (pending[idx]) begin
                sel      = idx;
                any_pend = 1'b1;
            end
        end
    end

    always_comb begin
        st_nxt = st;
        case (st)
            S_IDLE:  if (any_pend) st_nxt = S_STEP;
            S_STEP:  st_nxt = S_IDLE;
            default: st_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st        <= S_IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            upd_valid <= 1'b0;
            upd_voice <= '0;
        end else begin
            st        <= st_nxt;
            upd_valid <= (st == S_STEP);
            if (st == S_IDLE && any_pend)
                grant <= sel;
            if (st == S_STEP) begin
                upd_voice <= grant;
                rr_ptr    <= (grant == VW'(VOICES - 1)) ? '0 : grant + 1'b1;
            end
        end
    end
endmodule

// File: doc/lfsr_sched.md
# lfsr_sched

Time-multiplexed noise-voice scheduler around a single shared LFSR step engine. Holds per-voice LFSR state, taps, direction and period. A round-robin arbiter advances one voice per service slot when its period divider expires. It sits between the register/config bus and the audio mixer, replacing one LFSR instance per voice.

## Interface
- DEPTH, 8, LFSR width in bits (≥2)
- VOICES, 4, number of noise voices (≥2)
- DIVW, 16, period divider width
- VW, $clog2(VOICES), voice index width
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cfg_we  in  1  config write strobe, one cycle
- cfg_voice  in  VW  target voice of config write
- cfg_period  in  DIVW  step interval: voice requests a step every cfg_period+1 clocks
- cfg_taps  in  DEPTH  feedback tap mask
- cfg_dir  in  1  0 = shift right (feedback into MSB), 1 = shift left (feedback into LSB)
- cfg_enable  in  1  voice run enable
- cfg_seed  in  1  when 1, the write also reloads voice state to all-ones
- value_bus  out  VOICES*DEPTH  concatenated voice states, voice v at [v*DEPTH +: DEPTH]
- noise  out  VOICES  bit 0 of each voice state
- upd_valid  out  1  one-cycle pulse: a voice was stepped last cycle
- upd_voice  out  VW  voice stepped, valid with upd_valid
- overrun  out  VOICES  sticky per-voice missed-step flag
- busy  out  1  FSM in S_STEP

## Operation
- Per voice: state[DEPTH], taps, dir, enable, period, down-counter cnt, pending, overrun.
- Divider: enabled voice with cnt==0 sets pending and reloads cnt=period. Otherwise cnt decrements. Disabled voice holds cnt and never sets pending.
- Step function: nxt = ^(state & taps). dir 0: state <= {nxt, state[DEPTH-1:1]}. dir 1: state <= {state[DEPTH-2:0], nxt}.
- FSM S_IDLE: if any pending, grant = first pending index at or after rr_ptr (wrapping), go S_STEP. Otherwise stay.
- FSM S_STEP: write the stepped state[grant], clear pending[grant], rr_ptr = (grant+1) mod VOICES, go S_IDLE.
- Expiry in the same cycle as pending clear: pending stays 1 (set wins), no overrun.
- Expiry while pending already 1 and not being cleared: overrun[v] <= 1. Only a config write to v or reset clears it.
- Config write to v: taps, dir, enable and period load. cnt = cfg_period. pending[v] and overrun[v] clear. With cfg_seed, state[v] = all-ones.
- Config write to the voice being written back in S_STEP: the config write wins for state (if seeding) and pending. The write-back is dropped only if cfg_seed=1; otherwise the stepped state is kept.
- Reset: every state = all-ones; taps, dir, enable, period and cnt = 0; pending, overrun, rr_ptr and grant = 0; FSM S_IDLE; upd_valid=0, upd_voice=0, busy=0.

## Timing
- Expiry edge t sets pending. S_IDLE samples it at t+1 and selects. The state write occurs at the end of the S_STEP cycle (t+2). upd_valid/upd_voice are high in cycle t+3. value_bus reflects the new state from t+3.
- Throughput: one step per 2 clocks in total. Sustainable without overrun only if every enabled voice satisfies period+1 ≥ 2*(number of enabled voices).
- period=0 with more than one voice enabled guarantees overrun.
- value_bus and noise are direct register outputs, no combinational path from inputs.
- Reset deassertion mid-operation is not special. Reset assertion aborts S_STEP with no write-back.

## Configuration
- LFSR_SCHED_LOCKUP_GUARD_EN defined: if a computed step result is all-zero, all-ones is written instead. An all-zero state can never be produced, even with a degenerate tap mask.
- Undefined: the step result is written unmodified; an all-zero state persists (locks up).

## Test plan
- Reset, then write voice0 taps=8'hB8, dir=0, period=3, enable, seed. Required: upd_valid for voice0 every 4 clocks; state sequence FF→7F→BF; overrun=0.
- Same taps with dir=1 from FF. Required: first step yields 8'hFE.
- Enable all 4 voices with period=0. Required: upd_voice order 0,1,2,3,0… at one per 2 clocks; all overrun bits set; config write to voice2 clears only overrun[2].
- Voices 1 and 3 expire in the same cycle with rr_ptr=2. Required: voice3 is serviced first, then voice1.
- Taps=8'h00 from FF with dir=0. Required: with LFSR_SCHED_LOCKUP_GUARD_EN, the state reads 7F,3F,…,01, then FF instead of 00. Without the macro, it reaches 00 and holds.
- Assert reset during S_STEP. Required: every state reads FF, busy=0, no upd_valid pulse follows.
